// File: rtl/rca_spare_analyzer.sv
// Built-in self-test analyzer for a ripple-carry adder with one spare slice:
// checks observed slice outputs against a golden ripple, then picks a shift-repair map.
module rca_spare_analyzer #(
  parameter int N_SLICE = 5,
  parameter int IDLE_TO = 63
) (
  input  logic               clk,
  input  logic               init,
  input  logic               start,
  input  logic [N_SLICE-1:0] pat_a,
  input  logic [N_SLICE-1:0] pat_b,
  input  logic               pat_c,
  input  logic               pat_valid,
  input  logic               pat_last,
  input  logic [N_SLICE-1:0] sf,
  input  logic [N_SLICE-1:0] cf,
  output logic               test,
  output logic               busy,
  output logic               done,
  output logic [N_SLICE-1:0] fault_map,
  output logic [N_SLICE-2:0] shift_sel,
  output logic               spare_bad,
  output logic               uncorr,
  output logic [5:0]         pat_cnt,
  output logic [1:0]         dbg_state
);

  localparam int IW = $clog2(IDLE_TO + 1);

  // Pattern handshake: there is no ready; a pattern is consumed on every
  // rising edge where pat_valid is high while the block is in SWEEP.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [N_SLICE-1:0] r_fault_map;
  logic [N_SLICE-2:0] r_shift_sel;
  logic               r_spare_bad;
  logic               r_uncorr;
  logic [5:0]         r_pat_cnt;
  logic [IW-1:0]      r_idle;
  logic               r_test;
  logic               r_busy;
  logic               r_done;

  logic [N_SLICE-1:0] w_gs;
  logic [N_SLICE-1:0] w_gc;
  logic [N_SLICE-1:0] w_mm;
  logic [N_SLICE-1:0] w_first;
  logic [N_SLICE-2:0] w_shift;
  logic               w_multi;

  always_comb begin
    logic v_cy;
    logic v_co;
    v_cy = pat_c;
    w_gs = '0;
    w_gc = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      v_co    = (pat_a[i] & pat_b[i]) | (pat_a[i] & v_cy) | (pat_b[i] & v_cy);
      w_gs[i] = pat_a[i] ^ pat_b[i] ^ v_cy;
      w_gc[i] = v_co;
      v_cy    = v_co;
    end
  end

  // Only the lowest mismatching slice is blamed; higher slices may just be
  // rippling a bad carry from below.
  always_comb begin
    logic v_found;
    w_mm    = (sf ^ w_gs) | (cf ^ w_gc);
    w_first = '0;
    v_found = 1'b0;
    for (int i = 0; i < N_SLICE; i++) begin
      if (w_mm[i] && !v_found) begin
        w_first[i] = 1'b1;
        v_found    = 1'b1;
      end
    end
  end

  // A single primary fault at k shifts every logical bit j>=k up by one slice.
  always_comb begin
    int   v_ones;
    logic v_or;
    v_ones  = 0;
    v_or    = 1'b0;
    w_shift = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      if (r_fault_map[i]) v_ones = v_ones + 1;
    end
    for (int j = 0; j < N_SLICE - 1; j++) begin
      v_or       = v_or | r_fault_map[j];
      w_shift[j] = v_or;
    end
    w_multi = (v_ones > 1);
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state     <= S_IDLE;
      r_fault_map <= '0;
      r_shift_sel <= '0;
      r_spare_bad <= 1'b0;
      r_uncorr    <= 1'b0;
      r_pat_cnt   <= '0;
      r_idle      <= '0;
      r_test      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_SWEEP;
            r_fault_map <= '0;
            r_shift_sel <= '0;
            r_spare_bad <= 1'b0;
            r_uncorr    <= 1'b0;
            r_pat_cnt   <= '0;
            r_idle      <= '0;
            r_test      <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (r_idle == IW'(IDLE_TO)) begin
            r_state  <= S_EVAL;
            r_uncorr <= 1'b1;
            r_test   <= 1'b0;
          end else if (pat_valid) begin
            r_fault_map <= r_fault_map | w_first;
            r_idle      <= '0;
            if (r_pat_cnt != 6'd63) r_pat_cnt <= r_pat_cnt + 6'd1;
            if (pat_last) begin
              r_state <= S_EVAL;
              r_test  <= 1'b0;
            end
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        S_EVAL: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (w_multi) begin
            r_uncorr    <= 1'b1;
            r_shift_sel <= '0;
          end else if (r_fault_map[N_SLICE-1]) begin
            r_spare_bad <= 1'b1;
            r_shift_sel <= '0;
          end else begin
            r_shift_sel <= w_shift;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign test      = r_test;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault_map = r_fault_map;
  assign shift_sel = r_shift_sel;
  assign spare_bad = r_spare_bad;
  assign uncorr    = r_uncorr;
  assign pat_cnt   = r_pat_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rca_spare_analyzer.sv
// Directed bench for rca_spare_analyzer: single-pattern vector table plus
// multi-cycle sequences for clean, stuck-carry, spare, double-fault, timeout and reset cases.
module tb_rca_spare_analyzer;

  logic       clk = 1'b0;
  logic       init, start, pat_c, pat_valid, pat_last;
  logic [4:0] pat_a, pat_b, sf, cf;
  logic       test, busy, done, spare_bad, uncorr;
  logic [4:0] fault_map;
  logic [3:0] shift_sel;
  logic [5:0] pat_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rca_spare_analyzer dut (
    .clk(clk), .init(init), .start(start),
    .pat_a(pat_a), .pat_b(pat_b), .pat_c(pat_c),
    .pat_valid(pat_valid), .pat_last(pat_last),
    .sf(sf), .cf(cf),
    .test(test), .busy(busy), .done(done),
    .fault_map(fault_map), .shift_sel(shift_sel),
    .spare_bad(spare_bad), .uncorr(uncorr),
    .pat_cnt(pat_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a, b;
    logic       c;
    logic [4:0] s, co;
    logic [4:0] fm;
    logic [3:0] sh;
    logic       spare;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level adder model: returns {cf, sf}; slice 'stuck' has its carry forced to 0.
  function automatic logic [9:0] ripple(input logic [4:0] a, input logic [4:0] b,
                                        input logic c, input int stuck);
    logic       cy;
    logic [4:0] s, co;
    cy = c;
    for (int i = 0; i < 5; i++) begin
      s[i]  = a[i] ^ b[i] ^ cy;
      co[i] = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
      if (i == stuck) co[i] = 1'b0;
      cy = co[i];
    end
    return {co, s};
  endfunction

  task automatic do_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_start_test"}, test, 1);
    check({name, "_start_fm"}, fault_map, 0);
    check({name, "_start_cnt"}, pat_cnt, 0);
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic c,
                      input logic [4:0] s, input logic [4:0] co, input logic last);
    pat_a = a; pat_b = b; pat_c = c; sf = s; cf = co;
    pat_valid = 1'b1;
    pat_last  = last;
    tick();
    pat_valid = 1'b0;
    pat_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 8) begin
      tick();
      k++;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic check_result(input string name, input logic [4:0] fm, input logic [3:0] sh,
                              input logic sp, input logic un, input logic [5:0] cnt);
    check({name, "_fault_map"}, fault_map, fm);
    check({name, "_shift_sel"}, shift_sel, sh);
    check({name, "_spare_bad"}, spare_bad, sp);
    check({name, "_uncorr"}, uncorr, un);
    check({name, "_pat_cnt"}, pat_cnt, cnt);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic clean_sweep(input string name);
    logic [4:0] a, b;
    logic       c;
    logic [9:0] r;
    do_start(name);
    for (int i = 0; i < 32; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      c = 1'($urandom_range(0, 1));
      r = ripple(a, b, c, -1);
      send(a, b, c, r[4:0], r[9:5], i == 31);
      if (i == 15) repeat (40) tick();
      if (i == 25) repeat (30) tick();
    end
    wait_done(name);
    check_result(name, 5'b00000, 4'b0000, 1'b0, 1'b0, 6'd32);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a, b, s;
    logic       c;
    logic [9:0] r;

    vt[0] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 4'b0000, 1'b0};
    vt[1] = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b11111, 5'b00000, 4'b0000, 1'b0};
    vt[2] = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b11110, 5'b00001, 4'b1111, 1'b0};
    vt[3] = '{5'b11111, 5'b00000, 1'b1, 5'b00010, 5'b11111, 5'b00010, 4'b1110, 1'b0};
    vt[4] = '{5'b00101, 5'b00011, 1'b0, 5'b00000, 5'b00111, 5'b01000, 4'b1000, 1'b0};
    vt[5] = '{5'b00101, 5'b00011, 1'b0, 5'b11100, 5'b00111, 5'b00100, 4'b1100, 1'b0};
    vt[6] = '{5'b00101, 5'b00011, 1'b0, 5'b01000, 5'b10111, 5'b10000, 4'b0000, 1'b1};
    vt[7] = '{5'b00101, 5'b00011, 1'b0, 5'b01000, 5'b00111, 5'b00000, 4'b0000, 1'b0};

    init = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    pat_a = '0; pat_b = '0; pat_c = 1'b0; sf = '0; cf = '0;
    #1;
    check("rst_test", test, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    check_result("rst", 5'b00000, 4'b0000, 1'b0, 1'b0, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    init = 1'b0;

    // Patterns offered while idle must be ignored.
    send(5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b1);
    check("idle_ignore_cnt", pat_cnt, 0);
    check("idle_ignore_fm", fault_map, 0);
    check("idle_ignore_state", dbg_state, 0);

    // One-pattern sweeps; every start after the first comes from DONE.
    for (int v = 0; v < 8; v++) begin
      do_start($sformatf("vec%0d", v));
      send(vt[v].a, vt[v].b, vt[v].c, vt[v].s, vt[v].co, 1'b1);
      check($sformatf("vec%0d_eval_busy", v), busy, 1);
      check($sformatf("vec%0d_eval_state", v), dbg_state, 2);
      wait_done($sformatf("vec%0d", v));
      check_result($sformatf("vec%0d", v), vt[v].fm, vt[v].sh, vt[v].spare, 1'b0, 6'd1);
    end

    clean_sweep("clean");

    // Slice 2 carry stuck at 0, wrong carry rippling into slices 3 and 4.
    do_start("stuck2");
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        a = 5'b11111; b = 5'b00000; c = 1'b1;
      end else begin
        a = 5'($urandom_range(0, 31));
        b = 5'($urandom_range(0, 31));
        c = 1'($urandom_range(0, 1));
      end
      r = ripple(a, b, c, 2);
      send(a, b, c, r[4:0], r[9:5], i == 15);
    end
    wait_done("stuck2");
    check_result("stuck2", 5'b00100, 4'b1100, 1'b0, 1'b0, 6'd16);

    // Spare-only fault on pattern 5.
    do_start("spare");
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      c = 1'($urandom_range(0, 1));
      r = ripple(a, b, c, -1);
      s = r[4:0];
      if (i == 4) s[4] = ~s[4];
      send(a, b, c, s, r[9:5], i == 7);
    end
    wait_done("spare");
    check_result("spare", 5'b10000, 4'b0000, 1'b1, 1'b0, 6'd8);
    // Faulty pattern while DONE must not disturb the result.
    send(5'b11111, 5'b00000, 1'b1, 5'b11111, 5'b00000, 1'b1);
    check_result("done_ignore", 5'b10000, 4'b0000, 1'b1, 1'b0, 6'd8);
    check("done_ignore_done", done, 1);

    // Two faults (slice 0 then slice 3); a start mid-sweep is ignored.
    do_start("double");
    for (int i = 0; i < 10; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      c = 1'($urandom_range(0, 1));
      r = ripple(a, b, c, -1);
      s = r[4:0];
      if (i == 2) s[0] = ~s[0];
      if (i == 8) s[3] = ~s[3];
      start = (i == 5);
      send(a, b, c, s, r[9:5], i == 9);
      start = 1'b0;
    end
    wait_done("double");
    check_result("double", 5'b01001, 4'b0000, 1'b0, 1'b1, 6'd10);

    // Timeout: 4 patterns, then 63 idle cycles, EVAL on the next edge.
    do_start("tmo");
    for (int i = 0; i < 4; i++) begin
      r = ripple(5'd3, 5'd9, 1'b0, -1);
      send(5'd3, 5'd9, 1'b0, r[4:0], r[9:5], 1'b0);
    end
    repeat (62) tick();
    check("tmo_still_sweep", dbg_state, 1);
    tick();
    check("tmo_edge_sweep", test, 1);
    tick();
    check("tmo_eval_state", dbg_state, 2);
    check("tmo_eval_uncorr", uncorr, 1);
    check("tmo_eval_test", test, 0);
    tick();
    check("tmo_done", done, 1);
    check_result("tmo", 5'b00000, 4'b0000, 1'b0, 1'b1, 6'd4);

    // Saturation of the pattern counter.
    do_start("sat");
    for (int i = 0; i < 70; i++) begin
      r = ripple(5'(i), 5'(i * 3), 1'(i), -1);
      send(5'(i), 5'(i * 3), 1'(i), r[4:0], r[9:5], i == 69);
    end
    wait_done("sat");
    check_result("sat", 5'b00000, 4'b0000, 1'b0, 1'b0, 6'd63);

    // Asynchronous reset in the middle of a faulty sweep.
    do_start("midrst");
    for (int i = 0; i < 10; i++) begin
      r = ripple(5'b11111, 5'b00000, 1'b1, -1);
      s = r[4:0];
      if (i == 1) s[1] = ~s[1];
      send(5'b11111, 5'b00000, 1'b1, s, r[9:5], 1'b0);
    end
    check("midrst_pre_fm", fault_map, 5'b00010);
    #2;
    init = 1'b1;
    #1;
    check("midrst_async_state", dbg_state, 0);
    check("midrst_async_test", test, 0);
    check("midrst_async_busy", busy, 0);
    check_result("midrst_async", 5'b00000, 4'b0000, 1'b0, 1'b0, 6'd0);
    tick();
    @(negedge clk);
    init = 1'b0;
    tick();
    check("midrst_idle_state", dbg_state, 0);
    check("midrst_idle_done", done, 0);
    clean_sweep("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
